spi_master_shifter: RTL and testbench

Data path and frame controller for the SPI master. It accepts parallel words from the user side and latches the frame configuration. It launches a frame on the SCK generator and serialises the word onto MOSI using the generator's edge strobes. It also deserialises MISO and returns the received word with a one-cycle valid pulse. It sits between the user/register interface and the SCK generator, and consumes the generator's `sck_first_edge`, `sck_second_edge`, `cs` and `spi_finish`.

---
 rtl/spi_master_shifter_if.sv | 27 ++
 rtl/spi_master_shifter.sv | 174 +++++++++++++++++
 tb/tb_spi_master_shifter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_shifter_if.sv
// User-side word/config bus of the SPI master data path.
// The user (master modport) offers words and frame config; the shifter (slave) returns received words.
interface spi_master_shifter_if #(
  parameter int SPI_MAX_WIDTH_LOG = 4
);
  localparam int DW = 2 ** SPI_MAX_WIDTH_LOG;

  logic                         tx_valid;
  logic                         tx_ready;
  logic [DW-1:0]                tx_data;
  logic [SPI_MAX_WIDTH_LOG-1:0] cfg_width;
  logic                         cfg_cpha;
  logic                         cfg_cpol;
  logic                         cfg_lsb_first;
  logic                         rx_valid;
  logic [DW-1:0]                rx_data;

  modport master (
    output tx_valid, tx_data, cfg_width, cfg_cpha, cfg_cpol, cfg_lsb_first,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, cfg_width, cfg_cpha, cfg_cpol, cfg_lsb_first,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master frame controller: latches a word plus frame config, requests a frame from the
// SCK generator, shifts MOSI/MISO on the generator's edge strobes and returns the received word.
module spi_master_shifter #(
  parameter int SPI_MAX_WIDTH_LOG = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_master_shifter_if.slave          usr,
  output logic                         spi_start,
  output logic [SPI_MAX_WIDTH_LOG-1:0] spi_width,
  output logic                         cpol,
  input  logic                         sck_first_edge,
  input  logic                         sck_second_edge,
  input  logic                         cs,
  input  logic                         spi_finish,
  output logic                         mosi,
  input  logic                         miso
);

  localparam int DW = 2 ** SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_MAX_WIDTH_LOG + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                       state_q, state_d;
  logic [DW-1:0]                tx_shift_q, tx_shift_d;
  logic [DW-1:0]                rx_shift_q, rx_shift_d;
  logic [CW-1:0]                bit_cnt_q, bit_cnt_d;
  logic                         cpha_q, cpha_d;
  logic                         lsb_first_q, lsb_first_d;
  logic                         first_pend_q, first_pend_d;
  logic                         tx_ready_q, tx_ready_d;
  logic                         spi_start_q, spi_start_d;
  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width_q, spi_width_d;
  logic                         cpol_q, cpol_d;
  logic                         mosi_q, mosi_d;
  logic                         rx_valid_q, rx_valid_d;
  logic [DW-1:0]                rx_data_q, rx_data_d;

  // DW-1-w equals ~w because DW-1 is all ones in the width field.
  logic [SPI_MAX_WIDTH_LOG-1:0] cfg_align_sh;
  logic [SPI_MAX_WIDTH_LOG-1:0] frame_align_sh;
  logic [DW-1:0]                tx_aligned;
  logic                         bits_left;
  logic                         shift_en;
  logic                         sample_en;

  assign cfg_align_sh   = ~usr.cfg_width;
  assign frame_align_sh = ~spi_width_q;
  assign tx_aligned     = usr.cfg_lsb_first ? usr.tx_data : (usr.tx_data << cfg_align_sh);
  assign bits_left      = (bit_cnt_q != ({1'b0, spi_width_q} + CW'(1)));
  assign shift_en       = bits_left && (cpha_q ? sck_first_edge : sck_second_edge);
  assign sample_en      = bits_left && (cpha_q ? sck_second_edge : sck_first_edge);

  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    cpha_d       = cpha_q;
    lsb_first_d  = lsb_first_q;
    first_pend_d = first_pend_q;
    spi_start_d  = spi_start_q;
    spi_width_d  = spi_width_q;
    cpol_d       = cpol_q;
    mosi_d       = mosi_q;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;

    unique case (state_q)
      IDLE: begin
        if (usr.tx_valid && tx_ready_q) begin
          spi_width_d  = usr.cfg_width;
          cpol_d       = usr.cfg_cpol;
          cpha_d       = usr.cfg_cpha;
          lsb_first_d  = usr.cfg_lsb_first;
          rx_shift_d   = '0;
          bit_cnt_d    = '0;
          first_pend_d = 1'b1;
          tx_shift_d   = tx_aligned;
          mosi_d       = usr.cfg_lsb_first ? tx_aligned[0] : tx_aligned[DW-1];
          spi_start_d  = 1'b1;
          state_d      = LOAD;
        end
      end

      LOAD: begin
        if (!cs) begin
          spi_start_d = 1'b0;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        if (spi_finish) begin
          rx_data_d  = lsb_first_q ? (rx_shift_q >> frame_align_sh)
                                   : (rx_shift_q & ({DW{1'b1}} >> frame_align_sh));
          rx_valid_d = 1'b1;
          state_d    = DONE;
        end else begin
          // With cpha=1 the first leading edge only presents the bit already on MOSI.
          if (shift_en) begin
            if (cpha_q && first_pend_q) begin
              first_pend_d = 1'b0;
            end else if (lsb_first_q) begin
              tx_shift_d = tx_shift_q >> 1;
              mosi_d     = tx_shift_q[1];
            end else begin
              tx_shift_d = tx_shift_q << 1;
              mosi_d     = tx_shift_q[DW-2];
            end
          end
          if (sample_en) begin
            rx_shift_d = lsb_first_q ? {miso, rx_shift_q[DW-1:1]}
                                     : {rx_shift_q[DW-2:0], miso};
            bit_cnt_d  = bit_cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        mosi_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      cpha_q       <= 1'b0;
      lsb_first_q  <= 1'b0;
      first_pend_q <= 1'b0;
      tx_ready_q   <= 1'b1;
      spi_start_q  <= 1'b0;
      spi_width_q  <= '0;
      cpol_q       <= 1'b0;
      mosi_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      cpha_q       <= cpha_d;
      lsb_first_q  <= lsb_first_d;
      first_pend_q <= first_pend_d;
      tx_ready_q   <= tx_ready_d;
      spi_start_q  <= spi_start_d;
      spi_width_q  <= spi_width_d;
      cpol_q       <= cpol_d;
      mosi_q       <= mosi_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
    end
  end

  assign usr.tx_ready = tx_ready_q;
  assign usr.rx_valid = rx_valid_q;
  assign usr.rx_data  = rx_data_q;
  assign spi_start    = spi_start_q;
  assign spi_width    = spi_width_q;
  assign cpol         = cpol_q;
  assign mosi         = mosi_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter: a table of frames driven through a simple SCK
// generator model, plus hand sequences for busy/config hold-off and mid-frame reset.
module tb_spi_master_shifter;

  logic        clk;
  logic        rst_n;
  logic        spi_start;
  logic [3:0]  spi_width;
  logic        cpol;
  logic        sck_first_edge;
  logic        sck_second_edge;
  logic        cs;
  logic        spi_finish;
  logic        mosi;
  logic        miso;

  int n_chk;
  int n_fail;

  spi_master_shifter_if #(.SPI_MAX_WIDTH_LOG(4)) usr ();

  spi_master_shifter #(.SPI_MAX_WIDTH_LOG(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .usr             (usr),
    .spi_start       (spi_start),
    .spi_width       (spi_width),
    .cpol            (cpol),
    .sck_first_edge  (sck_first_edge),
    .sck_second_edge (sck_second_edge),
    .cs              (cs),
    .spi_finish      (spi_finish),
    .mosi            (mosi),
    .miso            (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lsb;
    logic        cpha;
    logic        cpol;
    logic [3:0]  width;
    logic [15:0] tx;
    logic [15:0] miso_w;
    logic [15:0] exp_mosi;   // bit i = i-th bit expected on MOSI
    logic [15:0] exp_rx;
    int          extra;      // additional edge pairs after the last bit
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept(input vec_t v, input bit hold);
    usr.tx_valid      = 1'b1;
    usr.tx_data       = v.tx;
    usr.cfg_width     = v.width;
    usr.cfg_cpha      = v.cpha;
    usr.cfg_cpol      = v.cpol;
    usr.cfg_lsb_first = v.lsb;
    tick();
    chk("accept_tx_ready", 32'(usr.tx_ready), 32'd0);
    chk("accept_spi_start", 32'(spi_start), 32'd1);
    chk("accept_first_mosi", 32'(mosi), 32'(v.exp_mosi[0]));
    chk("accept_spi_width", 32'(spi_width), 32'(v.width));
    chk("accept_cpol", 32'(cpol), 32'(v.cpol));
    if (!hold) usr.tx_valid = 1'b0;
  endtask

  task automatic edge_pair;
    sck_first_edge = 1'b1;
    tick();
    sck_first_edge = 1'b0;
    tick();
    sck_second_edge = 1'b1;
    tick();
    sck_second_edge = 1'b0;
    tick();
  endtask

  task automatic body(input vec_t v);
    logic [15:0] seq;
    logic        last;
    int          idx;
    seq = '0;
    tick();
    cs = 1'b0;
    tick();
    chk("cs_fall_spi_start", 32'(spi_start), 32'd0);
    for (int i = 0; i <= int'(v.width); i++) begin
      idx  = v.lsb ? i : int'(v.width) - i;
      miso = v.miso_w[idx];
      if (!v.cpha) seq[i] = mosi;
      sck_first_edge = 1'b1;
      tick();
      sck_first_edge = 1'b0;
      if (v.cpha) seq[i] = mosi;
      tick();
      sck_second_edge = 1'b1;
      tick();
      sck_second_edge = 1'b0;
      tick();
    end
    chk("mosi_sequence", 32'(seq), 32'(v.exp_mosi));
    chk("frame_spi_width", 32'(spi_width), 32'(v.width));
    last = mosi;
    for (int j = 0; j < v.extra; j++) begin
      miso = ~miso;
      edge_pair();
      chk("extra_edge_mosi_stable", 32'(mosi), 32'(last));
    end
    cs         = 1'b1;
    spi_finish = 1'b1;
    tick();
    spi_finish = 1'b0;
    chk("done_rx_valid", 32'(usr.rx_valid), 32'd1);
    chk("done_rx_data", 32'(usr.rx_data), 32'(v.exp_rx));
    chk("done_tx_ready", 32'(usr.tx_ready), 32'd0);
    tick();
    chk("idle_rx_valid", 32'(usr.rx_valid), 32'd0);
    chk("idle_tx_ready", 32'(usr.tx_ready), 32'd1);
    chk("idle_mosi", 32'(mosi), 32'd0);
    chk("idle_rx_data_held", 32'(usr.rx_data), 32'(v.exp_rx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t a;
    vec_t b;
    n_chk  = 0;
    n_fail = 0;

    //        lsb   cpha  cpol  width  tx        miso      exp_mosi  exp_rx    extra
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd7,  16'h00A5, 16'h003C, 16'h00A5, 16'h003C, 3};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 4'd15, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd0,  16'h0001, 16'h0001, 16'h0001, 16'h0001, 2};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 4'd0,  16'hFFFE, 16'h0001, 16'h0000, 16'h0001, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'd3,  16'h0003, 16'h0006, 16'h000C, 16'h0006, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 4'd11, 16'h0ABC, 16'h05A3, 16'h0ABC, 16'h05A3, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 4'd7,  16'h001E, 16'h00C1, 16'h0078, 16'h00C1, 0};

    rst_n             = 1'b0;
    usr.tx_valid      = 1'b0;
    usr.tx_data       = '0;
    usr.cfg_width     = '0;
    usr.cfg_cpha      = 1'b0;
    usr.cfg_cpol      = 1'b0;
    usr.cfg_lsb_first = 1'b0;
    sck_first_edge    = 1'b0;
    sck_second_edge   = 1'b0;
    cs                = 1'b1;
    spi_finish        = 1'b0;
    miso              = 1'b0;
    tick();
    tick();
    chk("rst_tx_ready", 32'(usr.tx_ready), 32'd1);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_spi_width", 32'(spi_width), 32'd0);
    chk("rst_cpol", 32'(cpol), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_rx_valid", 32'(usr.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(usr.rx_data), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      accept(vecs[k], 1'b0);
      body(vecs[k]);
      tick();
    end

    // tx_valid held high with a new word and new width while the first frame runs
    a       = vecs[0];
    a.extra = 0;
    accept(a, 1'b1);
    usr.cfg_width = 4'd3;
    usr.tx_data   = 16'h0005;
    body(a);
    tick();
    chk("busy_second_accept", 32'(spi_start), 32'd1);
    chk("busy_second_width", 32'(spi_width), 32'd3);
    chk("busy_second_first_mosi", 32'(mosi), 32'd0);
    usr.tx_valid = 1'b0;
    b = '{1'b0, 1'b0, 1'b0, 4'd3, 16'h0005, 16'h0009, 16'h000A, 16'h0009, 0};
    body(b);
    tick();

    // reset asserted in the middle of a shifting frame
    accept(vecs[1], 1'b0);
    tick();
    cs = 1'b0;
    tick();
    miso = 1'b1;
    for (int j = 0; j < 3; j++) edge_pair();
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_ready", 32'(usr.tx_ready), 32'd1);
    chk("midrst_spi_start", 32'(spi_start), 32'd0);
    chk("midrst_spi_width", 32'(spi_width), 32'd0);
    chk("midrst_cpol", 32'(cpol), 32'd0);
    chk("midrst_mosi", 32'(mosi), 32'd0);
    chk("midrst_rx_valid", 32'(usr.rx_valid), 32'd0);
    chk("midrst_rx_data", 32'(usr.rx_data), 32'd0);
    cs = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    spi_finish = 1'b1;
    tick();
    spi_finish = 1'b0;
    chk("postrst_finish_ignored", 32'(usr.rx_valid), 32'd0);
    tick();
    chk("postrst_no_rx_valid", 32'(usr.rx_valid), 32'd0);
    accept(vecs[1], 1'b0);
    body(vecs[1]);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
